// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding, opcodes and PC step for the fetch stage
package fetch_unit_pkg;
  typedef enum logic [1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_OUT    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;
  localparam logic [31:0] FETCH_PC_STEP = 32'd4;
  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_ADDI  = 6'd2;
  localparam logic [5:0] OP_LOAD  = 6'd3;
  localparam logic [5:0] OP_STORE = 6'd4;
  localparam logic [5:0] OP_BNEZ  = 6'd5;
  localparam logic [5:0] OP_HALT  = 6'd6;
  localparam logic [5:0] OP_JAL   = 6'd7;
  localparam logic [5:0] OP_RET   = 6'd8;
  function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [25:0] arg);
    return {op, arg};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decode and redirect signals of the fetch stage
interface fetch_unit_if;
  logic        imem_req_po;
  logic [31:0] imem_addr_po;
  logic        imem_ack_pi;
  logic [31:0] imem_data_pi;
  logic [31:0] instr_po;
  logic [31:0] pc_po;
  logic        instr_valid_po;
  logic        instr_ready_pi;
  logic        redirect_pi;
  logic [31:0] redirect_target_pi;
  logic        halt_pi;
  logic        halted_po;
  modport master (
    output imem_req_po, imem_addr_po, instr_po, pc_po, instr_valid_po, halted_po,
    input  imem_ack_pi, imem_data_pi, instr_ready_pi, redirect_pi, redirect_target_pi, halt_pi
  );
  modport slave (
    input  imem_req_po, imem_addr_po, instr_po, pc_po, instr_valid_po, halted_po,
    output imem_ack_pi, imem_data_pi, instr_ready_pi, redirect_pi, redirect_target_pi, halt_pi
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg: fetch PC with increment/redirect and squash flag for a dead in-flight request
module fetch_unit_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        set_squash,
  input  logic        clr_squash,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        squash
);
  assign pc_next = redirect ? target : inc ? pc + PC_STEP : pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      squash <= 1'b0;
    end else begin
      pc     <= pc_next;
      squash <= set_squash | (squash & ~clr_squash);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch FSM issuing one imem request at a time and holding the fetched
// instruction for decode until accepted, redirected or halted
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = FETCH_PC_STEP
) (
  input logic         clk_pi,
  input logic         reset_pi,
  fetch_unit_if.master bus
);
  fetch_state_e state_q, state_d;
  logic        req_q, valid_q, halted_q, squash, ack_v;
  logic        inc, redir, set_sq, clr_sq, capture;
  logic [31:0] fetch_pc, pc_next, addr_q, instr_q, pc_q;
  fetch_unit_pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk(clk_pi), .rst(reset_pi), .inc(inc), .redirect(redir),
    .target(bus.redirect_target_pi), .set_squash(set_sq), .clr_squash(clr_sq),
    .pc(fetch_pc), .pc_next(pc_next), .squash(squash)
  );
  // an ack only counts against a request we actually have on the bus
  assign ack_v = bus.imem_ack_pi & req_q;
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    redir   = 1'b0;
    set_sq  = 1'b0;
    clr_sq  = 1'b0;
    capture = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        redir   = bus.redirect_pi;
        clr_sq  = ack_v;
        set_sq  = bus.redirect_pi & req_q & ~ack_v;
        capture = ack_v & ~squash & ~bus.redirect_pi;
        inc     = capture;
        state_d = capture ? FETCH_OUT : FETCH_REQ;
      end
      FETCH_OUT: begin
        redir   = bus.redirect_pi & ~(bus.instr_ready_pi & bus.halt_pi);
        state_d = (bus.instr_ready_pi & bus.halt_pi) ? FETCH_HALTED :
                  (bus.redirect_pi | bus.instr_ready_pi) ? FETCH_REQ : FETCH_OUT;
      end
      default: state_d = state_q;
    endcase
  end
  // req drops for a cycle after every ack; the address latches only while idle or on ack
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state_q  <= FETCH_REQ;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      instr_q  <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= (state_d == FETCH_REQ) & ~ack_v;
      addr_q   <= (!req_q || ack_v) ? pc_next : addr_q;
      instr_q  <= capture ? bus.imem_data_pi : instr_q;
      pc_q     <= capture ? fetch_pc : pc_q;
      valid_q  <= state_d == FETCH_OUT;
      halted_q <= state_d == FETCH_HALTED;
    end
  end
  assign bus.imem_req_po    = req_q;
  assign bus.imem_addr_po   = addr_q;
  assign bus.instr_po       = instr_q;
  assign bus.pc_po          = pc_q;
  assign bus.instr_valid_po = valid_q;
  assign bus.halted_po      = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable memory responder
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int unsigned lat = 1;
  int unsigned cnt = 0;
  logic [31:0] mem [0:255];
  logic [31:0] exp_instr [3];
  fetch_unit_if bus ();
  fetch_unit #(.RESET_PC(32'h0)) dut (.clk_pi(clk), .reset_pi(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // one clock edge, then the memory decides whether to ack during the coming cycle
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.imem_ack_pi) bus.imem_ack_pi = 1'b0;
    else if (bus.imem_req_po) begin
      if (cnt == lat) begin
        bus.imem_ack_pi  = 1'b1;
        bus.imem_data_pi = mem[bus.imem_addr_po[9:2]];
        cnt = 0;
      end else cnt++;
    end else cnt = 0;
  endtask

  task automatic wait_valid(input string tag, input int n);
    for (int i = 0; i < n && !bus.instr_valid_po; i++) tick();
    chk(tag, {31'd0, bus.instr_valid_po}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input int n);
    for (int i = 0; i < n && !bus.imem_req_po; i++) tick();
    chk(tag, {31'd0, bus.imem_req_po}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.imem_ack_pi = 1'b0;
    cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mk_instr(OP_ADDI, 26'(i));
    mem[0] = 32'h0420_0008;
    exp_instr[0] = 32'h0420_0008;
    exp_instr[1] = 32'h0800_0001;
    exp_instr[2] = 32'h0800_0002;
    bus.imem_ack_pi = 1'b0;
    bus.imem_data_pi = '0;
    bus.instr_ready_pi = 1'b0;
    bus.redirect_pi = 1'b0;
    bus.redirect_target_pi = '0;
    bus.halt_pi = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'd0, bus.imem_req_po}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid_po}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted_po}, 32'd0);
    chk("rst_instr", bus.instr_po, 32'd0);
    chk("rst_pc", bus.pc_po, 32'd0);
    // sequential fetch, latency 1, decode always ready
    rst = 1'b0;
    lat = 1;
    bus.instr_ready_pi = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req("seq_req", 10);
      chk("seq_addr", bus.imem_addr_po, 32'(4 * k));
      wait_valid("seq_valid", 10);
      chk("seq_pc", bus.pc_po, 32'(4 * k));
      chk("seq_instr", bus.instr_po, exp_instr[k]);
      tick();
      chk("seq_pulse", {31'd0, bus.instr_valid_po}, 32'd0);
    end
    // latency 3, decode stalls for 4 cycles
    bus.instr_ready_pi = 1'b0;
    do_reset();
    lat = 3;
    wait_valid("stall_valid", 20);
    for (int i = 0; i < 4; i++) begin
      chk("stall_instr", bus.instr_po, 32'h0420_0008);
      chk("stall_pc", bus.pc_po, 32'h0);
      chk("stall_hold_valid", {31'd0, bus.instr_valid_po}, 32'd1);
      chk("stall_req", {31'd0, bus.imem_req_po}, 32'd0);
      tick();
    end
    bus.instr_ready_pi = 1'b1;
    tick();
    bus.instr_ready_pi = 1'b0;
    chk("accept_valid", {31'd0, bus.instr_valid_po}, 32'd0);
    chk("accept_req", {31'd0, bus.imem_req_po}, 32'd1);
    chk("accept_addr", bus.imem_addr_po, 32'h4);
    // redirect in OUT beats ready
    wait_valid("out_valid", 20);
    chk("out_pc", bus.pc_po, 32'h4);
    bus.redirect_pi = 1'b1;
    bus.redirect_target_pi = 32'h40;
    bus.instr_ready_pi = 1'b1;
    tick();
    bus.redirect_pi = 1'b0;
    bus.instr_ready_pi = 1'b0;
    chk("redir_out_valid", {31'd0, bus.instr_valid_po}, 32'd0);
    chk("redir_out_req", {31'd0, bus.imem_req_po}, 32'd1);
    chk("redir_out_addr", bus.imem_addr_po, 32'h40);
    wait_valid("redir_out_next", 20);
    chk("redir_out_pc", bus.pc_po, 32'h40);
    chk("redir_out_instr", bus.instr_po, 32'h0800_0010);
    // redirect while the request at 0x8 is outstanding
    lat = 2;
    bus.redirect_pi = 1'b1;
    bus.redirect_target_pi = 32'h8;
    tick();
    chk("sq_addr8", bus.imem_addr_po, 32'h8);
    bus.redirect_target_pi = 32'h100;
    tick();
    bus.redirect_pi = 1'b0;
    chk("sq_hold_req", {31'd0, bus.imem_req_po}, 32'd1);
    chk("sq_hold_addr", bus.imem_addr_po, 32'h8);
    tick();
    chk("sq_ack_addr", bus.imem_addr_po, 32'h8);
    chk("sq_ack_seen", {31'd0, bus.imem_ack_pi}, 32'd1);
    tick();
    chk("sq_drop_req", {31'd0, bus.imem_req_po}, 32'd0);
    chk("sq_drop_valid", {31'd0, bus.instr_valid_po}, 32'd0);
    tick();
    chk("sq_reissue_req", {31'd0, bus.imem_req_po}, 32'd1);
    chk("sq_reissue_addr", bus.imem_addr_po, 32'h100);
    wait_valid("sq_valid", 20);
    chk("sq_pc", bus.pc_po, 32'h100);
    chk("sq_instr", bus.instr_po, 32'h0800_0040);
    // halt beats a simultaneous redirect
    bus.instr_ready_pi = 1'b1;
    bus.halt_pi = 1'b1;
    bus.redirect_pi = 1'b1;
    bus.redirect_target_pi = 32'h200;
    tick();
    bus.halt_pi = 1'b0;
    chk("halt_flag", {31'd0, bus.halted_po}, 32'd1);
    chk("halt_valid", {31'd0, bus.instr_valid_po}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      bus.redirect_pi = i[0];
      tick();
      chk("halt_req", {31'd0, bus.imem_req_po}, 32'd0);
    end
    chk("halt_stay", {31'd0, bus.halted_po}, 32'd1);
    bus.redirect_pi = 1'b0;
    bus.instr_ready_pi = 1'b0;
    do_reset();
    chk("halt_rst_flag", {31'd0, bus.halted_po}, 32'd0);
    tick();
    chk("halt_rst_req", {31'd0, bus.imem_req_po}, 32'd1);
    chk("halt_rst_addr", bus.imem_addr_po, 32'h0);
    // asynchronous reset while a request at 0x1C is outstanding
    lat = 1;
    wait_valid("ar_valid", 20);
    chk("ar_pc0", bus.pc_po, 32'h0);
    lat = 1000;
    bus.redirect_pi = 1'b1;
    bus.redirect_target_pi = 32'h1C;
    tick();
    bus.redirect_pi = 1'b0;
    chk("ar_addr1c", bus.imem_addr_po, 32'h1C);
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("ar_req", {31'd0, bus.imem_req_po}, 32'd0);
    chk("ar_addr", bus.imem_addr_po, 32'h0);
    chk("ar_instr", bus.instr_po, 32'h0);
    chk("ar_valid0", {31'd0, bus.instr_valid_po}, 32'd0);
    tick();
    rst = 1'b0;
    lat = 1;
    cnt = 0;
    bus.imem_ack_pi = 1'b1;
    bus.imem_data_pi = 32'hDEAD_BEEF;
    tick();
    chk("ar_late_req", {31'd0, bus.imem_req_po}, 32'd1);
    chk("ar_late_addr", bus.imem_addr_po, 32'h0);
    chk("ar_late_valid", {31'd0, bus.instr_valid_po}, 32'd0);
    tick();
    chk("ar_late_valid2", {31'd0, bus.instr_valid_po}, 32'd0);
    wait_valid("ar_first", 20);
    chk("ar_first_pc", bus.pc_po, 32'h0);
    chk("ar_first_instr", bus.instr_po, 32'h0420_0008);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Presents one 32-bit instruction plus its PC to decode over a valid/ready handshake.
- Accepts redirects (BNEZ taken, JAL, RET) from the execute/decode side and stops permanently on HALT.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first instruction fetched after reset
PC_STEP, 4, byte increment between sequential instructions

Ports:
clk_pi  in  1  clock, all state on rising edge
reset_pi  in  1  asynchronous, active-high reset
imem_req_po  out  1  instruction-memory request
imem_addr_po  out  32  byte address of request (= fetch PC)
imem_ack_pi  in  1  memory response valid; imem_data_pi valid this cycle
imem_data_pi  in  32  instruction word returned
instr_po  out  32  instruction presented to decode
pc_po  out  32  byte address of instr_po
instr_valid_po  out  1  instr_po/pc_po valid
instr_ready_pi  in  1  decode accepts instr_po this cycle
redirect_pi  in  1  control-flow change request
redirect_target_pi  in  32  new fetch PC when redirect_pi=1
halt_pi  in  1  accepted instruction was HALT; only meaningful with instr_valid_po & instr_ready_pi
halted_po  out  1  fetch stopped permanently

Behaviour:
- Clock clk_pi; reset_pi asynchronous, active-high. This is fixed.
- Reset values:
  - state=REQ, fetch_pc=RESET_PC, squash=0
  - instr_po=0, pc_po=0, instr_valid_po=0, halted_po=0
  - imem_req_po=0 while reset asserted; it rises the first edge after release.
- State REQ:
  - imem_req_po=1, imem_addr_po=fetch_pc.
  - Once raised, req and addr stay stable until imem_ack_pi. There is no abandonment mid-transaction.
  - Ack arrives no earlier than 1 cycle after req rises; latency is unbounded.
- REQ, ack with squash=0:
  - instr_po<=imem_data_pi, pc_po<=fetch_pc, instr_valid_po<=1
  - fetch_pc<=fetch_pc+PC_STEP (32-bit wrap, no flag); go to OUT.
- REQ, ack with squash=1:
  - Discard data, squash<=0, stay in REQ; req drops for 1 cycle, then re-issues at fetch_pc.
- REQ, redirect_pi (with or without ack the same cycle):
  - fetch_pc<=redirect_target_pi.
  - If a request is outstanding and ack is not present this cycle, squash<=1.
  - If ack is present the same cycle, the data is discarded and squash stays 0.
- State OUT:
  - imem_req_po=0, instr_valid_po=1; instr_po and pc_po are held stable until accepted.
- OUT, instr_ready_pi & halt_pi: instr_valid_po<=0; go to HALTED. Halt beats a simultaneous redirect.
- OUT, redirect_pi, no halt: instr_valid_po<=0, fetch_pc<=redirect_target_pi; go to REQ. Redirect beats ready.
- OUT, instr_ready_pi only: instr_valid_po<=0; go to REQ. Next request is issued the following cycle.
- HALTED:
  - halted_po=1, imem_req_po=0, instr_valid_po=0.
  - All inputs are ignored until reset_pi.
- Throughput: one instruction per (mem latency + 2) cycles minimum. No fetch overlap.
- Reset mid-transaction: state clears immediately. A late ack after reset release, while req=0, is ignored.
- Redirect target alignment: low 2 bits are passed through unchanged; alignment is not checked.

Decomposition:
- Shared package/header holds:
  - state encoding: FETCH_REQ=2'd0, FETCH_OUT=2'd1, FETCH_HALTED=2'd2
  - the opcode defines already used by decode (NOP, ADD, ADDI, LOAD, STORE, BNEZ, HALT, JAL, RET) for bench stimulus
  - a PC_STEP constant
- One natural sub-module: fetch_pc_reg, holding the PC register with increment/redirect/squash bookkeeping.
- The top level holds the FSM and output register.

Test Plan:
- Reset release, memory ack latency 1, ready always 1:
  - imem_addr_po sequence is 0x0, 0x4, 0x8.
  - pc_po values match; instr_valid_po pulses once per fetch.
- Latency 3, data 0x04200008 at addr 0x0, ready held 0 for 4 cycles:
  - instr_po=0x04200008 and pc_po=0x0 stay stable with valid=1.
  - imem_req_po stays 0 until ready.
- Redirect to 0x40 in OUT together with ready=1:
  - Instruction is dropped.
  - Next imem_addr_po=0x40; pc_po of the next valid instruction = 0x40.
- Redirect to 0x100 while a request at 0x8 is outstanding (ack 2 cycles later):
  - addr 0x8 is held until ack; its data is discarded.
  - Req re-issues at 0x100; no instruction with pc_po=0x8 appears.
- Accepted instruction with halt_pi=1 and simultaneous redirect_pi=1:
  - halted_po=1 the next cycle; req stays 0 for 20 cycles.
  - Reset then restarts at RESET_PC.
- reset_pi asserted asynchronously mid-REQ with fetch_pc=0x1C:
  - Outputs clear before the next edge.
  - After release, first imem_addr_po=RESET_PC.
